// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST session sequencer.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int unsigned DEF_SIG_W = 16;
    localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/bist_pattern_cnt.sv
// Pattern counter: clear, enable, saturation at N_PATTERNS, terminal-count flag.
module bist_pattern_cnt #(
    parameter int unsigned N_PATTERNS = 200,
    parameter int unsigned CNT_W      = bist_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    // One extra bit so N_PATTERNS == 2**CNT_W still compares correctly.
    localparam logic [CNT_W:0] LIMIT    = (CNT_W+1)'(N_PATTERNS);
    localparam logic [CNT_W:0] LIMIT_M1 = (CNT_W+1)'(N_PATTERNS - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && ({1'b0, cnt} != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = en && ({1'b0, cnt} == LIMIT_M1);

endmodule

// File: rtl/bist_sequencer.sv
// BIST session sequencer (Moore FSM driving PRPG/MISR, signature check).
// Optional BIST_ABORT_EN adds an `abort` input that ends a running session early.
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int unsigned      N_PATTERNS = 200,
    parameter int unsigned      CNT_W      = DEF_CNT_W,
    parameter int unsigned      SIG_W      = DEF_SIG_W,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = SIG_W'(16'hA5C3)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef BIST_ABORT_EN
    input  logic             abort,
`endif
    input  logic [SIG_W-1:0] misr_sig,
    output logic             lfsr_load,
    output logic             lfsr_en,
    output logic             misr_clr,
    output logic             misr_en,
    output logic             test_mode,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pat_cnt
);

    state_t state, state_nx;
    logic   in_session;
    logic   abort_act;
    logic   cnt_clr, cnt_en, cnt_tc;
    logic   pass_q;

    assign in_session = (state == ST_INIT) || (state == ST_RUN) ||
                        (state == ST_FLUSH) || (state == ST_CHECK);

`ifdef BIST_ABORT_EN
    assign abort_act = abort && in_session;
`else
    assign abort_act = 1'b0;
`endif

    assign cnt_clr = (state == ST_INIT);
    assign cnt_en  = (state == ST_RUN) && !abort_act;

    bist_pattern_cnt #(
        .N_PATTERNS (N_PATTERNS),
        .CNT_W      (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (pat_cnt),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (abort_act) begin
            state_nx = ST_DONE;
        end else begin
            unique case (state)
                ST_IDLE:  if (start) state_nx = ST_INIT;
                ST_INIT:  state_nx = ST_RUN;
                ST_RUN:   if (cnt_tc) state_nx = ST_FLUSH;
                ST_FLUSH: state_nx = ST_CHECK;
                ST_CHECK: state_nx = ST_DONE;
                ST_DONE:  if (start) state_nx = ST_INIT;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    // Result is cleared on the edge entering INIT so it never shows a stale pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            pass_q <= 1'b0;
        end else if (abort_act) begin
            pass_q <= 1'b0;
        end else if (state == ST_CHECK) begin
            pass_q <= (misr_sig == GOLDEN_SIG);
        end else if (((state == ST_IDLE) || (state == ST_DONE)) && start) begin
            pass_q <= 1'b0;
        end
    end

    always_comb begin
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        misr_clr  = 1'b0;
        misr_en   = 1'b0;
        test_mode = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_INIT: begin
                lfsr_load = 1'b1;
                misr_clr  = 1'b1;
                test_mode = 1'b1;
            end
            ST_RUN: begin
                lfsr_en   = 1'b1;
                misr_en   = 1'b1;
                test_mode = 1'b1;
            end
            ST_FLUSH: begin
                misr_en   = 1'b1;
                test_mode = 1'b1;
            end
            ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign busy = in_session;
    assign pass = pass_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed self-checking bench for bist_sequencer (N_PATTERNS=4, GOLDEN_SIG=16'h1234).
module tb_bist_sequencer;

    localparam int unsigned CNT_W = 3;

    // {lfsr_load, lfsr_en, misr_clr, misr_en, test_mode, busy, done, pass}
    localparam logic [7:0] O_IDLE  = 8'b0000_0000;
    localparam logic [7:0] O_INIT  = 8'b1010_1100;
    localparam logic [7:0] O_RUN   = 8'b0101_1100;
    localparam logic [7:0] O_FLUSH = 8'b0001_1100;
    localparam logic [7:0] O_CHECK = 8'b0000_0100;
    localparam logic [7:0] O_DPASS = 8'b0000_0011;
    localparam logic [7:0] O_DFAIL = 8'b0000_0010;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [15:0]      misr_sig = 16'h0000;
    logic             lfsr_load, lfsr_en, misr_clr, misr_en, test_mode, busy, done, pass;
    logic [CNT_W-1:0] pat_cnt;
    logic [7:0]       outs;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Expected state after edges E0..E6 of a session started from IDLE; E7 is DONE.
    logic [7:0]       seq_out [8] = '{O_INIT, O_RUN, O_RUN, O_RUN, O_RUN, O_FLUSH, O_CHECK, O_DPASS};
    logic [CNT_W-1:0] seq_cnt [8] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};

    assign outs = {lfsr_load, lfsr_en, misr_clr, misr_en, test_mode, busy, done, pass};

    always #5 clk = ~clk;

    bist_sequencer #(
        .N_PATTERNS (4),
        .CNT_W      (CNT_W),
        .SIG_W      (16),
        .GOLDEN_SIG (16'h1234)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef BIST_ABORT_EN
        .abort     (abort),
`endif
        .misr_sig  (misr_sig),
        .lfsr_load (lfsr_load),
        .lfsr_en   (lfsr_en),
        .misr_clr  (misr_clr),
        .misr_en   (misr_en),
        .test_mode (test_mode),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .pat_cnt   (pat_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (outs !== O_IDLE || pat_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state outs=%b cnt=%0d required outs=%b cnt=0", outs, pat_cnt, O_IDLE);
        end
    endtask

    task automatic test_idle_quiet();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (outs !== O_IDLE || pat_cnt !== '0) begin
                errors++;
                $display("FAIL idle_quiet[%0d] outs=%b cnt=%0d required outs=%b cnt=0", i, outs, pat_cnt, O_IDLE);
            end
        end
    endtask

    task automatic test_pass_session();
        do_reset();
        misr_sig = 16'h1234;
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = 1'b0;
            checks++;
            if (outs !== seq_out[i] || pat_cnt !== seq_cnt[i]) begin
                errors++;
                $display("FAIL pass_session E%0d outs=%b cnt=%0d required outs=%b cnt=%0d",
                         i, outs, pat_cnt, seq_out[i], seq_cnt[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (outs !== O_DPASS || pat_cnt !== 3'd4) begin
                errors++;
                $display("FAIL pass_hold[%0d] outs=%b cnt=%0d required outs=%b cnt=4", i, outs, pat_cnt, O_DPASS);
            end
        end
    endtask

    task automatic test_fail_session();
        logic [7:0] exp;
        do_reset();
        misr_sig = 16'h1235;
        start = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            start = 1'b0;
            exp = (i >= 7) ? O_DFAIL : seq_out[i];
            checks++;
            if (outs !== exp || pat_cnt !== seq_cnt[(i > 7) ? 7 : i]) begin
                errors++;
                $display("FAIL fail_session E%0d outs=%b cnt=%0d required outs=%b", i, outs, pat_cnt, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        do_reset();
        misr_sig = 16'h1234;
        start = 1'b1;
        // start held high throughout: E0..E7 first session, E8 restart, E9..E15 second
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 8) begin
                checks++;
                if (outs !== O_INIT) begin
                    errors++;
                    $display("FAIL restart_init outs=%b required %b", outs, O_INIT);
                end
                start = 1'b0;
            end else begin
                exp = seq_out[(i > 8) ? i - 8 : i];
                checks++;
                if (outs !== exp || pat_cnt !== seq_cnt[(i > 8) ? i - 8 : i]) begin
                    errors++;
                    $display("FAIL back_to_back E%0d outs=%b cnt=%0d required outs=%b", i, outs, pat_cnt, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (outs !== O_RUN || pat_cnt !== 3'd2) begin
            errors++;
            $display("FAIL mid_run_pre outs=%b cnt=%0d required outs=%b cnt=2", outs, pat_cnt, O_RUN);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (outs !== O_IDLE || pat_cnt !== '0) begin
            errors++;
            $display("FAIL mid_run_reset outs=%b cnt=%0d required outs=%b cnt=0", outs, pat_cnt, O_IDLE);
        end
        start = 1'b1;
        tick();
        checks++;
        if (outs !== O_IDLE || pat_cnt !== '0) begin
            errors++;
            $display("FAIL reset_beats_start outs=%b cnt=%0d required outs=%b cnt=0", outs, pat_cnt, O_IDLE);
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL post_reset_idle outs=%b required %b", outs, O_IDLE);
        end
    endtask

`ifdef BIST_ABORT_EN
    task automatic test_abort();
        do_reset();
        misr_sig = 16'h1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (outs !== O_DFAIL || pat_cnt !== 3'd2) begin
            errors++;
            $display("FAIL abort_run outs=%b cnt=%0d required outs=%b cnt=2", outs, pat_cnt, O_DFAIL);
        end
        tick();
        checks++;
        if (outs !== O_DFAIL || pat_cnt !== 3'd2) begin
            errors++;
            $display("FAIL abort_hold outs=%b cnt=%0d required outs=%b cnt=2", outs, pat_cnt, O_DFAIL);
        end
        do_reset();
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        checks++;
        if (outs !== O_IDLE || pat_cnt !== '0) begin
            errors++;
            $display("FAIL abort_idle outs=%b cnt=%0d required outs=%b cnt=0", outs, pat_cnt, O_IDLE);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle_quiet();
        test_pass_session();
        test_fail_session();
        test_back_to_back();
        test_reset_mid_run();
`ifdef BIST_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
